// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the device
//   using the host request-to-send sequence, then samples the device ACK.
//   The clock and data lines are open-drain: the *_oe outputs drive
//   external tristate buffers that pull the line low when set.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   tx_data      command byte, latched on accept
//   tx_valid     request to send tx_data (ignored while tx_ready=0)
//   tx_ready     block idle
//   ps2_clk_in   raw PS/2 clock line
//   ps2_data_in  raw PS/2 data line
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   tx_done      one-cycle pulse at the end of every transaction
//   tx_nack      with tx_done: device answered with ACK bit = 1
//   tx_timeout   with tx_done: transaction aborted on timeout

// Per-line conditioning: 2-flop synchroniser followed by a run-length
// glitch filter. The filtered level only changes after FILTER_LEN
// consecutive synchronised samples disagree with it.
module ps2_host_tx_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [1:0]    sync;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            filt    <= 1'b1;
            run_cnt <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                filt    <= sync[1];
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end
endmodule

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_timeout
);
    localparam int IW = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [7:0]    data_r;
    logic          parity_r;
    logic          nack_r;
    logic [3:0]    bit_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;

    logic clk_filt, data_filt, clk_prev;
    logic fall_clk;
    logic to_hit;

    ps2_host_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_clk_in),
        .filt  (clk_filt)
    );

    ps2_host_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ps2_data_in),
        .filt  (data_filt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_prev <= 1'b1;
        else        clk_prev <= clk_filt;
    end

    // High in the first cycle the filtered clock reads 0 after reading 1.
    assign fall_clk = clk_prev & ~clk_filt;
    assign to_hit   = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign tx_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            data_r      <= '0;
            parity_r    <= 1'b0;
            nack_r      <= 1'b0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_nack     <= 1'b0;
            tx_timeout  <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_nack    <= 1'b0;
            tx_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        data_r      <= tx_data;
                        parity_r    <= ~^tx_data;
                        inh_cnt     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_oe <= 1'b1;   // start bit
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                // One cycle with both lines low, then hand the clock back
                // to the device while keeping the start bit on data.
                RTS: begin
                    ps2_clk_oe <= 1'b0;
                    bit_cnt    <= '0;
                    to_cnt     <= '0;
                    state      <= SEND;
                end

                SEND, ACK, WAIT_IDLE: begin
                    if (to_hit) begin
                        // Timeout wins over any simultaneous clock edge.
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_done     <= 1'b1;
                        tx_timeout  <= 1'b1;
                        state       <= IDLE;
                    end else if (state == SEND) begin
                        if (fall_clk) begin
                            to_cnt  <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'd8) begin
                                ps2_data_oe <= ~data_r[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_data_oe <= ~parity_r;
                            end else begin
                                ps2_data_oe <= 1'b0;   // stop bit
                                state       <= ACK;
                            end
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else if (state == ACK) begin
                        if (fall_clk) begin
                            nack_r <= data_filt;
                            to_cnt <= '0;
                            state  <= WAIT_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end else begin
                        // Wait for the device to release both lines.
                        if (clk_filt && data_filt) begin
                            tx_done <= 1'b1;
                            tx_nack <= nack_r;
                            state   <= IDLE;
                        end else if (fall_clk) begin
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Expected frames/status are pushed to a scoreboard when a command is
// issued and popped when tx_done appears.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int FLT  = 4;
    localparam int TO   = 2000;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_done, tx_nack, tx_timeout;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic glitch = 1'b0;

    // Open-drain wiring: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~glitch;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_nack     (tx_nack),
        .tx_timeout  (tx_timeout)
    );

    typedef struct {
        logic [10:0] frame;
        logic        nack;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic nack, input logic tmo);
        exp_t e;
        e.frame = {1'b1, ~^d, d, 1'b0};
        e.nack  = nack;
        e.tmo   = tmo;
        exp_q.push_back(e);
    endtask

    // Present a byte and hold tx_valid until accepted; optionally keep it high.
    task automatic start_tx(input logic [7:0] d, input logic nack, input logic tmo, input bit hold);
        int n = 0;
        while (!tx_ready && n < 5000) begin tick(); n++; end
        chk("ready_before_tx", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        push_exp(d, nack, tmo);
        tick();
        if (!hold) tx_valid = 1'b0;
    endtask

    // Device: waits for RTS release, samples start bit, then generates 10
    // clocks sampling on rising edges, then an 11th clock for ACK. Returns
    // right after the final rising edge so the caller can catch tx_done.
    task automatic dev_frame(input bit do_ack, input int glitch_at, input int abort_at,
                             output logic [10:0] got, output bit ok);
        int n = 0;
        ok  = 1'b0;
        got = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 500) begin tick(); n++; end
        chk("rts_seen", (n < 500), 1);
        if (n >= 500) return;
        repeat (HALF) tick();
        got[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            if (i == abort_at) begin
                repeat (HALF / 2) tick();
                chk("pre_rst_data_oe", ps2_data_oe, 1);
                rst_n = 1'b0;
                #1;
                chk("rst_clk_oe", ps2_clk_oe, 0);
                chk("rst_data_oe", ps2_data_oe, 0);
                return;
            end
            repeat (HALF) tick();
            dev_clk = 1'b1;
            got[i] = ps2_data_in;
            if (i == glitch_at) begin
                repeat (HALF / 2) tick();
                glitch = 1'b1;
                repeat (2) tick();
                glitch = 1'b0;
                repeat (HALF - HALF / 2 - 2) tick();
            end else begin
                repeat (HALF) tick();
            end
        end
        repeat (HALF / 2) tick();
        dev_data = do_ack ? 1'b0 : 1'b1;
        repeat (HALF / 2) tick();
        dev_clk = 1'b0;
        repeat (HALF) tick();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        ok = 1'b1;
    endtask

    task automatic wait_done(input logic [10:0] frame);
        int   n = 0;
        exp_t e;
        while (!tx_done && n < 5000) begin tick(); n++; end
        chk("done_seen", tx_done, 1);
        chk("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("nack", tx_nack, e.nack);
            chk("timeout", tx_timeout, e.tmo);
            if (!e.tmo) chk("frame", frame, e.frame);
        end
    endtask

    initial begin
        logic [10:0] got;
        bit          ok;
        int          n;
        int          bad;

        repeat (3) tick();
        chk("rst_ready", tx_ready, 1);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_done", {tx_done, tx_nack, tx_timeout}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Device-initiated traffic while idle must not be disturbed.
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            dev_clk  = (i / 25) % 2 == 0;
            dev_data = (i / 60) % 2 == 0;
            tick();
            if (ps2_clk_oe || ps2_data_oe || !tx_ready) bad++;
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (20) tick();
        chk("idle_untouched", bad, 0);

        // 1: 0xED with inhibit/RTS timing
        start_tx(8'hED, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin tick(); n++; end
        chk("inhibit_len", n, INH);
        chk("rts_lines", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        tick();
        chk("send_lines", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        dev_frame(1'b1, 0, 0, got, ok);
        wait_done(got);
        tick();
        chk("done_one_cycle", tx_done, 0);
        chk("ready_after", tx_ready, 1);

        // 2: 0x01 then 0x00 back-to-back with tx_valid held high
        start_tx(8'h01, 1'b0, 1'b0, 1'b1);
        tx_data = 8'h00;
        push_exp(8'h00, 1'b0, 1'b0);
        dev_frame(1'b1, 0, 0, got, ok);
        wait_done(got);
        tick();
        chk("b2b_accept", {tx_ready, ps2_clk_oe}, 2'b01);
        tx_valid = 1'b0;
        dev_frame(1'b1, 0, 0, got, ok);
        wait_done(got);

        // 3: NACK
        start_tx(8'hF4, 1'b1, 1'b0, 1'b0);
        dev_frame(1'b0, 0, 0, got, ok);
        wait_done(got);

        // 4: timeout, device never clocks
        start_tx(8'h55, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 500) begin tick(); n++; end
        n = 0;
        while (!tx_done && n < 3000) begin tick(); n++; end
        chk("timeout_cycles", n, TO);
        wait_done(11'h0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ps2_clk_oe || ps2_data_oe) bad++;
            tick();
        end
        chk("timeout_released", bad, 0);

        // 5: glitch on clock mid-frame
        start_tx(8'hED, 1'b0, 1'b0, 1'b0);
        dev_frame(1'b1, 4, 0, got, ok);
        wait_done(got);

        // 6a: tx_valid during INHIBIT is ignored
        start_tx(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_ready) bad++;
        end
        tx_valid = 1'b0;
        chk("busy_not_ready", bad, 0);
        dev_frame(1'b1, 0, 0, got, ok);
        wait_done(got);

        // 6b: reset during bit 4
        repeat (5) tick();
        start_tx(8'h00, 1'b0, 1'b0, 1'b0);
        dev_frame(1'b1, 0, 4, got, ok);
        exp_q.delete();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
